// File: rtl/execute_stage.sv
// Y86-64 execute stage: ALU, condition codes, jXX/cmovXX evaluation and the M pipeline register.
// Optional iaddq support is enabled by defining EXECUTE_IADDQ_EN.
module execute_stage #(
   parameter logic [3:0] RNONE    = 4'hF,
   parameter logic [2:0] CC_RESET = 3'b100
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [3:0]  E_icode,
   input  logic [3:0]  E_ifun,
   input  logic [63:0] E_valA,
   input  logic [63:0] E_valB,
   input  logic [63:0] E_valC,
   input  logic [3:0]  E_dstE,
   input  logic [3:0]  E_dstM,
   input  logic        m_exc,
   input  logic        W_exc,
   input  logic        M_bubble,
   output logic [63:0] e_valE,
   output logic        e_Cnd,
   output logic [3:0]  e_dstE,
   output logic [2:0]  cc_out,
   output logic [3:0]  M_icode,
   output logic        M_Cnd,
   output logic [63:0] M_valE,
   output logic [63:0] M_valA,
   output logic [3:0]  M_dstE,
   output logic [3:0]  M_dstM
);

   localparam logic [3:0] I_NOP    = 4'h1;
   localparam logic [3:0] I_RRMOVQ = 4'h2;
   localparam logic [3:0] I_IRMOVQ = 4'h3;
   localparam logic [3:0] I_RMMOVQ = 4'h4;
   localparam logic [3:0] I_MRMOVQ = 4'h5;
   localparam logic [3:0] I_OPQ    = 4'h6;
   localparam logic [3:0] I_CALL   = 4'h8;
   localparam logic [3:0] I_RET    = 4'h9;
   localparam logic [3:0] I_PUSHQ  = 4'hA;
   localparam logic [3:0] I_POPQ   = 4'hB;
`ifdef EXECUTE_IADDQ_EN
   localparam logic [3:0] I_IADDQ  = 4'hC;
`endif

   // Returns {ZF, SF, OF, result}; unknown functions yield a zero result with OF clear.
   function automatic logic [66:0] alu_exec(input logic [3:0] fn,
                                            input logic signed [63:0] a,
                                            input logic signed [63:0] b);
      logic signed [63:0] r;
      logic               of;
      r  = '0;
      of = 1'b0;
      case (fn)
         4'h0: begin
            r  = b + a;
            of = (a[63] == b[63]) && (r[63] != a[63]);
         end
         4'h1: begin
            r  = b - a;
            of = (a[63] != b[63]) && (r[63] != b[63]);
         end
         4'h2: r = b & a;
         4'h3: r = b ^ a;
         default: r = '0;
      endcase
      return {(r == 64'sd0), r[63], of, r};
   endfunction

   function automatic logic cond_eval(input logic [3:0] fn, input logic [2:0] cc);
      logic zf, sf, of;
      {zf, sf, of} = cc;
      case (fn)
         4'h0:    return 1'b1;
         4'h1:    return (sf ^ of) | zf;
         4'h2:    return sf ^ of;
         4'h3:    return zf;
         4'h4:    return !zf;
         4'h5:    return !(sf ^ of);
         4'h6:    return !(sf ^ of) && !zf;
         default: return 1'b0;
      endcase
   endfunction

   logic signed [63:0] w_aluA;
   logic signed [63:0] w_aluB;
   logic [3:0]         w_alufun;
   logic               w_set_cc;
   logic [63:0]        w_res;
   logic               w_zf, w_sf, w_of;
   logic               w_cnd;

   logic [2:0]  r_cc;
   logic [3:0]  r_M_icode;
   logic        r_M_Cnd;
   logic [63:0] r_M_valE;
   logic [63:0] r_M_valA;
   logic [3:0]  r_M_dstE;
   logic [3:0]  r_M_dstM;

   always_comb begin
      w_aluA   = '0;
      w_aluB   = '0;
      w_alufun = 4'h0;
      w_set_cc = 1'b0;
      case (E_icode)
         I_RRMOVQ: w_aluA = E_valA;
         I_IRMOVQ: w_aluA = E_valC;
         I_RMMOVQ, I_MRMOVQ: begin
            w_aluA = E_valC;
            w_aluB = E_valB;
         end
         I_OPQ: begin
            w_aluA   = E_valA;
            w_aluB   = E_valB;
            w_alufun = E_ifun;
            w_set_cc = 1'b1;
         end
         I_CALL, I_PUSHQ: begin
            w_aluA = -64'sd8;
            w_aluB = E_valB;
         end
         I_RET, I_POPQ: begin
            w_aluA = 64'sd8;
            w_aluB = E_valB;
         end
`ifdef EXECUTE_IADDQ_EN
         I_IADDQ: begin
            w_aluA   = E_valC;
            w_aluB   = E_valB;
            w_set_cc = 1'b1;
         end
`endif
         default: ;
      endcase
      // Flags freeze while an exception is draining through M or W.
      w_set_cc = w_set_cc && !m_exc && !W_exc;
   end

   assign {w_zf, w_sf, w_of, w_res} = alu_exec(w_alufun, w_aluA, w_aluB);
   assign w_cnd  = cond_eval(E_ifun, r_cc);

   assign e_valE = w_res;
   assign e_Cnd  = w_cnd;
   assign e_dstE = (E_icode == I_RRMOVQ && !w_cnd) ? RNONE : E_dstE;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_cc      <= CC_RESET;
         r_M_icode <= I_NOP;
         r_M_Cnd   <= 1'b0;
         r_M_valE  <= '0;
         r_M_valA  <= '0;
         r_M_dstE  <= RNONE;
         r_M_dstM  <= RNONE;
      end else begin
         if (w_set_cc)
            r_cc <= {w_zf, w_sf, w_of};
         if (M_bubble) begin
            r_M_icode <= I_NOP;
            r_M_Cnd   <= 1'b0;
            r_M_valE  <= '0;
            r_M_valA  <= '0;
            r_M_dstE  <= RNONE;
            r_M_dstM  <= RNONE;
         end else begin
            r_M_icode <= E_icode;
            r_M_Cnd   <= w_cnd;
            r_M_valE  <= w_res;
            r_M_valA  <= E_valA;
            r_M_dstE  <= e_dstE;
            r_M_dstM  <= E_dstM;
         end
      end
   end

   assign cc_out  = r_cc;
   assign M_icode = r_M_icode;
   assign M_Cnd   = r_M_Cnd;
   assign M_valE  = r_M_valE;
   assign M_valA  = r_M_valA;
   assign M_dstE  = r_M_dstE;
   assign M_dstM  = r_M_dstM;

endmodule

// File: tb/tb_execute_stage.sv
module tb_execute_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  E_icode, E_ifun, E_dstE, E_dstM;
  logic [63:0] E_valA, E_valB, E_valC;
  logic        m_exc, W_exc, M_bubble;
  logic [63:0] e_valE;
  logic        e_Cnd;
  logic [3:0]  e_dstE;
  logic [2:0]  cc_out;
  logic [3:0]  M_icode;
  logic        M_Cnd;
  logic [63:0] M_valE, M_valA;
  logic [3:0]  M_dstE, M_dstM;

  execute_stage dut (
    .clk(clk), .rst_n(rst_n),
    .E_icode(E_icode), .E_ifun(E_ifun),
    .E_valA(E_valA), .E_valB(E_valB), .E_valC(E_valC),
    .E_dstE(E_dstE), .E_dstM(E_dstM),
    .m_exc(m_exc), .W_exc(W_exc), .M_bubble(M_bubble),
    .e_valE(e_valE), .e_Cnd(e_Cnd), .e_dstE(e_dstE), .cc_out(cc_out),
    .M_icode(M_icode), .M_Cnd(M_Cnd), .M_valE(M_valE), .M_valA(M_valA),
    .M_dstE(M_dstE), .M_dstM(M_dstM)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_run  = 0;
  int n_fail = 0;

  typedef enum int {K_VALE, K_CND, K_DSTE, K_CC, K_MICODE, K_MCND,
                    K_MVALE, K_MVALA, K_MDSTE, K_MDSTM} kind_t;
  typedef struct {
    int          cyc;
    kind_t       kind;
    logic [63:0] exp;
    string       name;
  } exp_t;
  exp_t sb[$];

  localparam logic [63:0] MAX  = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  function automatic logic [63:0] actual(input kind_t k);
    case (k)
      K_VALE:   return e_valE;
      K_CND:    return {63'd0, e_Cnd};
      K_DSTE:   return {60'd0, e_dstE};
      K_CC:     return {61'd0, cc_out};
      K_MICODE: return {60'd0, M_icode};
      K_MCND:   return {63'd0, M_Cnd};
      K_MVALE:  return M_valE;
      K_MVALA:  return M_valA;
      K_MDSTE:  return {60'd0, M_dstE};
      default:  return {60'd0, M_dstM};
    endcase
  endfunction

  task automatic chk(input int off, input kind_t k, input logic [63:0] v, input string nm);
    exp_t e;
    e.cyc  = cyc + off;
    e.kind = k;
    e.exp  = v;
    e.name = nm;
    sb.push_back(e);
  endtask

  task automatic step(input logic [3:0] ic, input logic [3:0] fn,
                      input logic [63:0] a, input logic [63:0] b, input logic [63:0] c,
                      input logic [3:0] de, input logic [3:0] dm,
                      input logic me, input logic we, input logic bub, input logic rn);
    @(posedge clk);
    #1;
    E_icode = ic; E_ifun = fn;
    E_valA = a; E_valB = b; E_valC = c;
    E_dstE = de; E_dstM = dm;
    m_exc = me; W_exc = we; M_bubble = bub; rst_n = rn;
  endtask

  always @(negedge clk) begin
    int i;
    logic [63:0] act;
    i = 0;
    while (i < sb.size()) begin
      if (sb[i].cyc == cyc) begin
        act = actual(sb[i].kind);
        n_run++;
        if (act !== sb[i].exp) begin
          n_fail++;
          $display("FAIL %s: got %h, expected %h (cycle %0d)", sb[i].name, act, sb[i].exp, cyc);
        end
        sb.delete(i);
      end else begin
        i++;
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    E_icode = 4'h1; E_ifun = 4'h0;
    E_valA = '0; E_valB = '0; E_valC = '0;
    E_dstE = 4'hF; E_dstM = 4'hF;
    m_exc = 1'b0; W_exc = 1'b0; M_bubble = 1'b0;

    step(4'h1, 4'h0, 0, 0, 0, 4'hF, 4'hF, 0, 0, 0, 1);
    n_run++;
    if (cc_out !== 3'b100) begin
      n_fail++;
      $display("FAIL direct_rst_cc: got %b", cc_out);
    end
    n_run++;
    if (M_icode !== 4'h1) begin
      n_fail++;
      $display("FAIL direct_rst_M_icode: got %h", M_icode);
    end
    n_run++;
    if (M_dstE !== 4'hF) begin
      n_fail++;
      $display("FAIL direct_rst_M_dstE: got %h", M_dstE);
    end
    n_run++;
    if (M_dstM !== 4'hF) begin
      n_fail++;
      $display("FAIL direct_rst_M_dstM: got %h", M_dstM);
    end
    chk(0, K_CC,     3'b100, "rst_cc");
    chk(0, K_MICODE, 4'h1,   "rst_M_icode");
    chk(0, K_MCND,   0,      "rst_M_Cnd");
    chk(0, K_MVALE,  0,      "rst_M_valE");
    chk(0, K_MVALA,  0,      "rst_M_valA");
    chk(0, K_MDSTE,  4'hF,   "rst_M_dstE");
    chk(0, K_MDSTM,  4'hF,   "rst_M_dstM");

    step(4'h6, 4'h0, MAX, MAX, 0, 4'h2, 4'hF, 0, 0, 0, 1);
    chk(0, K_VALE,   64'hFFFF_FFFF_FFFF_FFFE, "add_ovf_valE");
    chk(1, K_CC,     3'b011, "add_ovf_cc");
    chk(1, K_MICODE, 4'h6,   "add_M_icode");
    chk(1, K_MVALE,  64'hFFFF_FFFF_FFFF_FFFE, "add_M_valE");
    chk(1, K_MVALA,  MAX,    "add_M_valA");
    chk(1, K_MDSTE,  4'h2,   "add_M_dstE");

    step(4'h6, 4'h1, 5, 5, 0, 4'h2, 4'hF, 0, 0, 0, 1);
    chk(0, K_VALE, 0,      "sub_eq_valE");
    chk(0, K_CND,  0,      "sub_cnd_le_preedge");
    chk(1, K_CC,   3'b100, "sub_eq_cc");

    step(4'h7, 4'h3, 0, 0, 64'h40, 4'hF, 4'hF, 0, 0, 0, 1);
    chk(0, K_CND,    1,    "je_cnd");
    chk(1, K_MCND,   1,    "je_M_Cnd");
    chk(1, K_MICODE, 4'h7, "je_M_icode");

    step(4'h7, 4'h4, 0, 0, 64'h40, 4'hF, 4'hF, 0, 0, 0, 1);
    chk(0, K_CND,  0, "jne_cnd");
    chk(1, K_MCND, 0, "jne_M_Cnd");

    step(4'h6, 4'h0, 1, 1, 0, 4'h2, 4'hF, 0, 0, 0, 1);
    chk(0, K_VALE, 2,      "add_small_valE");
    chk(1, K_CC,   3'b000, "add_small_cc");

    step(4'h2, 4'h2, 64'h55, 0, 0, 4'h3, 4'hF, 0, 0, 0, 1);
    chk(0, K_CND,   0,      "cmovl_false_cnd");
    chk(0, K_DSTE,  4'hF,   "cmovl_false_dstE");
    chk(0, K_VALE,  64'h55, "cmovl_valE");
    chk(1, K_MDSTE, 4'hF,   "cmovl_false_M_dstE");
    chk(1, K_MVALE, 64'h55, "cmovl_M_valE");

    step(4'h6, 4'h1, 1, 0, 0, 4'h2, 4'hF, 0, 0, 0, 1);
    chk(0, K_VALE, ONES,   "sub_neg_valE");
    chk(1, K_CC,   3'b010, "sub_neg_cc");

    step(4'h2, 4'h2, 64'h55, 0, 0, 4'h3, 4'hF, 0, 0, 0, 1);
    chk(0, K_CND,   1,    "cmovl_true_cnd");
    chk(0, K_DSTE,  4'h3, "cmovl_true_dstE");
    chk(1, K_MDSTE, 4'h3, "cmovl_true_M_dstE");

    step(4'h6, 4'h3, 64'hF0F0, 64'h0FF0, 0, 4'h5, 4'hF, 1, 0, 0, 1);
    chk(0, K_VALE,  64'hFF00, "xor_valE");
    chk(1, K_CC,    3'b010,   "xor_mexc_cc_held");
    chk(1, K_MVALE, 64'hFF00, "xor_mexc_M_valE");
    chk(1, K_MDSTE, 4'h5,     "xor_mexc_M_dstE");

    step(4'h6, 4'h2, 0, 0, 0, 4'h5, 4'hF, 0, 1, 0, 1);
    chk(1, K_CC, 3'b010, "and_wexc_cc_held");

    step(4'hA, 4'h0, 64'h33, 64'h100, 0, 4'h4, 4'hF, 0, 0, 0, 1);
    chk(0, K_VALE,   64'hF8, "push_valE");
    chk(1, K_MVALE,  64'hF8, "push_M_valE");
    chk(1, K_MICODE, 4'hA,   "push_M_icode");
    chk(1, K_MVALA,  64'h33, "push_M_valA");

    step(4'h5, 4'h0, 0, 64'h20, 64'h10, 4'hF, 4'h7, 0, 0, 0, 1);
    chk(0, K_VALE,  64'h30, "mrmov_valE");
    chk(1, K_MDSTM, 4'h7,   "mrmov_M_dstM");

    step(4'h6, 4'h4, 3, 5, 0, 4'h2, 4'hF, 0, 0, 0, 1);
    chk(0, K_VALE, 0, "opq_badfun_valE");

    step(4'h7, 4'h7, 0, 0, 0, 4'hF, 4'hF, 0, 0, 0, 1);
    chk(0, K_CND, 0, "jxx_badfun_cnd");

    step(4'h6, 4'h1, 1, 0, 0, 4'h2, 4'hF, 0, 0, 0, 1);
    chk(1, K_CC, 3'b010, "pre_bubble_cc");

    step(4'h6, 4'h0, 0, 0, 0, 4'h4, 4'hF, 0, 0, 1, 1);
    chk(1, K_MICODE, 4'h1,   "bubble_M_icode");
    chk(1, K_MDSTE,  4'hF,   "bubble_M_dstE");
    chk(1, K_MVALE,  0,      "bubble_M_valE");
    chk(1, K_MCND,   0,      "bubble_M_Cnd");
    chk(1, K_CC,     3'b100, "bubble_cc_updates");

    step(4'h6, 4'h0, MAX, MAX, 0, 4'h2, 4'hF, 0, 0, 0, 1);
    chk(1, K_CC, 3'b011, "pre_reset_cc");

    step(4'h6, 4'h0, MAX, MAX, 0, 4'h2, 4'hF, 0, 0, 1, 0);
    chk(1, K_CC,     3'b100, "reset_overrides_cc");
    chk(1, K_MICODE, 4'h1,   "reset_overrides_M_icode");
    chk(1, K_MDSTE,  4'hF,   "reset_overrides_M_dstE");

    step(4'hC, 4'h0, 0, 64'h3, 64'h5, 4'h6, 4'hF, 0, 0, 0, 1);
    chk(0, K_DSTE, 4'h6, "iaddq_dstE");
`ifdef EXECUTE_IADDQ_EN
    chk(0, K_VALE, 64'h8,  "iaddq_valE");
    chk(1, K_CC,   3'b000, "iaddq_cc");
`else
    chk(0, K_VALE, 0,      "iaddq_off_valE");
    chk(1, K_CC,   3'b100, "iaddq_off_cc");
`endif

    step(4'h1, 4'h0, 0, 0, 0, 4'hF, 4'hF, 0, 0, 0, 1);
    repeat (3) @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      n_run++;
      n_fail++;
      $display("FAIL %s: never checked, expected %h by cycle %0d", sb[0].name, sb[0].exp, sb[0].cyc);
      void'(sb.pop_front());
    end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/execute_stage.md
# execute_stage

Execute stage of the five-stage Y86-64 pipeline: consumer of the E pipeline register (E_icode … E_valC). Computes the ALU result, owns the condition-code register (ZF/SF/OF), evaluates jXX/cmovXX conditions, and drives the M pipeline register with bubble support. Combinational e_* outputs feed the decode-stage forwarding and branch-misprediction logic.

## Interface
Parameters:
- RNONE, 4'hF, "no register" encoding for dstE/dstM
- CC_RESET, 3'b100, reset value of {ZF,SF,OF}

Ports:
- clk  in  1  pipeline clock; all state updates on posedge
- rst_n  in  1  synchronous, active-low reset
- E_icode, E_ifun  in  4 each  instruction code/function from E register
- E_valA, E_valB, E_valC  in  64 each  operands and constant from E register
- E_dstE, E_dstM  in  4 each  destination registers from E register
- m_exc  in  1  memory stage currently holds an exception
- W_exc  in  1  write-back stage currently holds an exception
- M_bubble  in  1  load NOP bubble into M register this edge
- e_valE  out  64  combinational ALU result
- e_Cnd  out  1  combinational condition result
- e_dstE  out  4  combinational effective dstE
- cc_out  out  3  registered {ZF,SF,OF}
- M_icode  out  4  M register
- M_Cnd  out  1  M register
- M_valE, M_valA  out  64 each  M register
- M_dstE, M_dstM  out  4 each  M register

## Operation
- aluA: E_valA for icode 2, 6; E_valC for 3, 4, 5, C; -8 for 8, A; +8 for 9, B; else 0.
- aluB: E_valB for 4, 5, 6, 8, 9, A, B, C; 0 for 2, 3; else 0.
- alufun: E_ifun when icode 6; else add. ifun 0 add (B+A), 1 sub (B−A), 2 and, 3 xor; ifun >3 on OPq gives e_valE = 0.
- 64-bit two's-complement arithmetic; carry out discarded.
- Flags: ZF = (result==0); SF = result[63]; OF for add = signs of A and B equal and differ from result; for sub = signs of B and A differ and result sign differs from B; and/xor: OF = 0.
- set_cc = (icode==6, or icode==C when enabled) && !m_exc && !W_exc.
- e_Cnd from current cc_out, by E_ifun: 0 always 1; 1 le (SF^OF)|ZF; 2 l SF^OF; 3 e ZF; 4 ne !ZF; 5 ge !(SF^OF); 6 g !(SF^OF)&!ZF; 7–F gives 0. Meaningful for icode 2 and 7; raw value forwarded for others.
- e_dstE = RNONE when icode==2 && !e_Cnd; else E_dstE.
- M register loads {E_icode, e_Cnd, e_valE, E_valA, e_dstE, E_dstM}.

## Timing
- e_valE/e_Cnd/e_dstE combinational, same cycle as E register contents.
- Latency E→M: one clock.
- CC written on the same edge that loads M; e_Cnd always uses pre-edge flags, so an OPq immediately preceding a jXX is visible to the jXX one cycle later.
- Reset (rst_n low at posedge): cc_out = CC_RESET; M_icode = 4'h1, M_Cnd = 0, M_valE = 0, M_valA = 0, M_dstE = RNONE, M_dstM = RNONE. Reset overrides M_bubble and set_cc.
- M_bubble high: M register loads the reset bubble values. CC update still follows set_cc, independent of M_bubble.
- m_exc or W_exc high: CC held, M register loads normally.

## Configuration
- EXECUTE_IADDQ_EN defined: icode C (iaddq) computes E_valC + E_valB, sets CC like OPq add, and passes E_dstE.
- Undefined: icode C treated as unknown: aluA = aluB = 0, e_valE = 0, no CC update; E_dstE still passed through.

## Test plan
- Reset, then hold rst_n high with idle inputs -> cc_out = 3'b100; M_icode = 1, M_dstE = F, M_dstM = F, all M values 0.
- OPq sub (6/1), valA = 5, valB = 5 -> e_valE = 0, next cc_out = 3'b100; following jXX je (7/3) gives e_Cnd = 1, jne gives 0.
- OPq add, valA = valB = 64'h7FFF_FFFF_FFFF_FFFF -> e_valE = 64'hFFFF_FFFF_FFFF_FFFE, cc_out = 3'b011.
- cmovl (2/2) with cc = 3'b000, E_dstE = 3 -> e_Cnd = 0, e_dstE = F, M_dstE = F next edge; with cc = 3'b010 -> M_dstE = 3.
- OPq xor with m_exc = 1 -> cc_out unchanged, M_valE = valA^valB. pushq (A) valB = 64'h100 -> e_valE = 64'hF8.
- M_bubble = 1 with a valid OPq in E -> M_icode = 1, M_dstE = F; cc_out still updated. rst_n low with M_bubble = 1 -> cc_out = 3'b100.
